// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: next-PC selection, stall-safe redirect
// buffering and the IF/ID PC/link fields.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_f,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic        adel_f,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus8_d,
    output logic        valid_d,
    output logic        redirect_pending
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [31:0] IM_LO = 32'h0000_3000;
    localparam logic [31:0] IM_HI = 32'h0000_6FFC;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pend;
    logic [31:0] pend_nx;
    logic [31:0] pc_f_nx;
    logic [31:0] pc_d_nx;
    logic [31:0] pc_plus8_nx;
    logic        valid_nx;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        trap;
    logic [31:0] trap_target;
    logic [31:0] seq_pc;
    logic [31:0] link_pc;

    // Branch wins over jump if upstream ever asserts both.
    assign redirect        = br_taken | jmp_valid;
    assign redirect_target = br_taken ? br_target : jmp_target;
    assign trap            = exc_req | eret_req;
    assign trap_target     = exc_req ? EXC_VECTOR : epc;
    assign seq_pc          = pc_f + 32'd4;
    assign link_pc         = pc_f + 32'd8;

    assign adel_f = (pc_f[1:0] != 2'b00) | (pc_f < IM_LO) | (pc_f > IM_HI);

    assign redirect_pending = (state == HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            pend       <= '0;
            pc_f       <= RESET_PC;
            pc_d       <= '0;
            pc_plus8_d <= 32'd8;
            valid_d    <= 1'b0;
        end else begin
            state      <= state_nx;
            pend       <= pend_nx;
            pc_f       <= pc_f_nx;
            pc_d       <= pc_d_nx;
            pc_plus8_d <= pc_plus8_nx;
            valid_d    <= valid_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pend_nx     = pend;
        pc_f_nx     = pc_f;
        pc_d_nx     = pc_d;
        pc_plus8_nx = pc_plus8_d;
        valid_nx    = valid_d;

        if (trap) begin
            // Trap overrides stall; the delay-slot instruction in F is dropped.
            pc_f_nx  = trap_target;
            valid_nx = 1'b0;
            pend_nx  = '0;
            state_nx = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (!stall_f) begin
                        pc_f_nx     = redirect ? redirect_target : seq_pc;
                        pc_d_nx     = pc_f;
                        pc_plus8_nx = link_pc;
                        valid_nx    = 1'b1;
                    end else if (redirect) begin
                        pend_nx  = redirect_target;
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall_f) begin
                        pc_f_nx     = redirect ? redirect_target : pend;
                        pc_d_nx     = pc_f;
                        pc_plus8_nx = link_pc;
                        valid_nx    = 1'b1;
                        pend_nx     = '0;
                        state_nx    = RUN;
                    end else if (redirect) begin
                        pend_nx = redirect_target;
                    end
                end
                default: begin
                    state_nx = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus randomized bench for pc_fetch_ctrl against a
// behavioural next-PC model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic        clk;
    logic        reset_n;
    logic        stall_f;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic        adel_f;
    logic [31:0] pc_d;
    logic [31:0] pc_plus8_d;
    logic        valid_d;
    logic        redirect_pending;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall_f          (stall_f),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp_valid        (jmp_valid),
        .jmp_target       (jmp_target),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .epc              (epc),
        .pc_f             (pc_f),
        .adel_f           (adel_f),
        .pc_d             (pc_d),
        .pc_plus8_d       (pc_plus8_d),
        .valid_d          (valid_d),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural fetch state plus a 0/1-entry redirect queue
    logic [31:0] m_pc_f;
    logic [31:0] m_pc_d;
    logic [31:0] m_p8;
    logic        m_valid;
    logic [31:0] m_pend_q[$];

    function automatic logic exp_adel(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [31:0] nxt;
        if (!reset_n) begin
            m_pc_f  = RST_PC;
            m_pc_d  = 32'd0;
            m_p8    = 32'd8;
            m_valid = 1'b0;
            m_pend_q.delete();
        end else if (exc_req || eret_req) begin
            m_pc_f  = exc_req ? EXC_PC : epc;
            m_valid = 1'b0;
            m_pend_q.delete();
        end else if (stall_f) begin
            if (br_taken || jmp_valid) begin
                m_pend_q.delete();
                m_pend_q.push_back(br_taken ? br_target : jmp_target);
            end
        end else begin
            if (br_taken)                 nxt = br_target;
            else if (jmp_valid)           nxt = jmp_target;
            else if (m_pend_q.size() > 0) nxt = m_pend_q[0];
            else                          nxt = m_pc_f + 32'd4;
            m_pc_d  = m_pc_f;
            m_p8    = m_pc_f + 32'd8;
            m_valid = 1'b1;
            m_pc_f  = nxt;
            m_pend_q.delete();
        end
    end

    // Per-cycle compare; pc_d fields are only meaningful with valid_d or in reset
    always @(negedge clk) begin
        check("pc_f", pc_f, m_pc_f);
        check("adel_f", {31'd0, adel_f}, {31'd0, exp_adel(m_pc_f)});
        check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
        check("redirect_pending", {31'd0, redirect_pending},
              {31'd0, m_pend_q.size() > 0});
        if (m_valid || !reset_n) begin
            check("pc_d", pc_d, m_pc_d);
            check("pc_plus8_d", pc_plus8_d, m_p8);
        end
    end

    task automatic idle();
        stall_f   = 1'b0;
        br_taken  = 1'b0;
        jmp_valid = 1'b0;
        exc_req   = 1'b0;
        eret_req  = 1'b0;
    endtask

    function automatic logic [31:0] rnd_tgt();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return 32'h3000 + ($urandom_range(0, 4095) << 2);
    endfunction

    initial begin
        reset_n    = 1'b0;
        br_target  = '0;
        jmp_target = '0;
        epc        = '0;
        idle();

        repeat (2) @(negedge clk);
        check("rst pc_f", pc_f, 32'h3000);
        check("rst pc_d", pc_d, 32'h0);
        check("rst pc_plus8_d", pc_plus8_d, 32'h8);
        check("rst valid_d", {31'd0, valid_d}, 32'd0);
        reset_n = 1'b1;

        @(negedge clk);
        check("run1 pc_f", pc_f, 32'h3004);
        check("run1 pc_d", pc_d, 32'h3000);
        check("run1 pc_plus8_d", pc_plus8_d, 32'h3008);
        check("run1 valid_d", {31'd0, valid_d}, 32'd1);
        @(negedge clk);
        check("run2 pc_f", pc_f, 32'h3008);
        br_taken  = 1'b1;
        br_target = 32'h3040;

        @(negedge clk);
        check("br pc_f", pc_f, 32'h3040);
        check("br delay slot pc_d", pc_d, 32'h3008);
        check("br valid_d", {31'd0, valid_d}, 32'd1);
        br_taken   = 1'b0;
        stall_f    = 1'b1;
        jmp_valid  = 1'b1;
        jmp_target = 32'h3100;

        @(negedge clk);
        jmp_valid = 1'b0;
        check("stall pc_f", pc_f, 32'h3040);
        check("stall pending", {31'd0, redirect_pending}, 32'd1);
        repeat (2) @(negedge clk);
        check("stall3 pc_f", pc_f, 32'h3040);
        stall_f = 1'b0;

        @(negedge clk);
        check("unstall pc_f", pc_f, 32'h3100);
        check("unstall pending", {31'd0, redirect_pending}, 32'd0);
        check("unstall pc_d", pc_d, 32'h3040);
        stall_f    = 1'b1;
        jmp_valid  = 1'b1;
        jmp_target = 32'h3200;

        @(negedge clk);
        check("hold2 pending", {31'd0, redirect_pending}, 32'd1);
        jmp_valid = 1'b0;
        exc_req   = 1'b1;

        @(negedge clk);
        check("exc pc_f", pc_f, 32'h4180);
        check("exc valid_d", {31'd0, valid_d}, 32'd0);
        check("exc pending", {31'd0, redirect_pending}, 32'd0);
        idle();

        @(negedge clk);
        check("handler pc_f", pc_f, 32'h4184);
        eret_req = 1'b1;
        epc      = 32'h3010;

        @(negedge clk);
        check("eret pc_f", pc_f, 32'h3010);
        eret_req  = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFC;

        @(negedge clk);
        check("top pc_f", pc_f, 32'hFFFF_FFFC);
        check("top adel_f", {31'd0, adel_f}, 32'd1);
        br_taken = 1'b0;

        @(negedge clk);
        check("wrap pc_f", pc_f, 32'h0);
        check("wrap pc_d", pc_d, 32'hFFFF_FFFC);
        check("wrap pc_plus8_d", pc_plus8_d, 32'h4);
        check("wrap adel_f", {31'd0, adel_f}, 32'd1);
        stall_f   = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h5000;

        @(negedge clk);
        check("pre-rst pending", {31'd0, redirect_pending}, 32'd1);
        br_taken = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async pc_f", pc_f, 32'h3000);
        check("async pc_d", pc_d, 32'h0);
        check("async pc_plus8_d", pc_plus8_d, 32'h8);
        check("async valid_d", {31'd0, valid_d}, 32'd0);
        check("async pending", {31'd0, redirect_pending}, 32'd0);

        @(negedge clk);
        idle();
        reset_n = 1'b1;
        @(negedge clk);
        check("restart pc_f", pc_f, 32'h3004);
        check("restart pc_d", pc_d, 32'h3000);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            stall_f    = ($urandom_range(0, 9) < 3);
            br_taken   = ($urandom_range(0, 9) < 2);
            jmp_valid  = ($urandom_range(0, 9) < 2);
            br_target  = rnd_tgt();
            jmp_target = rnd_tgt();
            exc_req    = ($urandom_range(0, 19) == 0);
            eret_req   = ($urandom_range(0, 19) == 0);
            epc        = rnd_tgt();
        end
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
